// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP multiplier: widths, bias, special patterns, flag indices, FSM states.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package fp_pkg;

   // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;
   localparam int FLG_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_MUL,
      ST_NORM,
      ST_PACK,
      ST_DONE
   } state_e;

   // Total word width for a given exponent/fraction split
   function automatic int fp_word_w(input int ew, input int mw);
      return 1 + ew + mw;
   endfunction

   function automatic int fp_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Pattern helpers return 64-bit words; callers keep the low W bits
   function automatic logic [63:0] fp_exp_ones(input int ew, input int mw);
      return ((64'd1 << ew) - 64'd1) << mw;
   endfunction

   function automatic logic [63:0] fp_qnan(input int ew, input int mw);
      return fp_exp_ones(ew, mw) | (64'd1 << (mw - 1));
   endfunction

   function automatic logic [63:0] fp_inf(input logic s, input int ew, input int mw);
      return fp_exp_ones(ew, mw) | ({63'd0, s} << (ew + mw));
   endfunction

   function automatic logic [63:0] fp_zero(input logic s, input int ew, input int mw);
      return {63'd0, s} << (ew + mw);
   endfunction

endpackage

// File: rtl/fp_mul_mant_iter.sv
// Iterative shift-add NxN unsigned multiplier, one multiplier bit per cycle, LSB first.
// Latency: loads on start_i, then N cycles; done_o is high during the last iteration cycle, prod_o valid afterwards.
// Backpressure: none; prod_o is held until the next start_i.
module fp_mul_mant_iter #(
   parameter int N = 11
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [N-1:0]   mcand_i,
   input  logic [N-1:0]   mplier_i,
   output logic           done_o,
   output logic [2*N-1:0] prod_o
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [2*N-1:0] mcand_q;
   logic [2*N-1:0] acc_q;
   logic [N-1:0]   mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic           busy_q;

   assign done_o = busy_q && (cnt_q == LAST);
   assign prod_o = acc_q;

   // Load operands on start, then add the shifted multiplicand for each set multiplier bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{N{1'b0}}, mcand_i};
         acc_q    <= '0;
         mplier_q <= mplier_i;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP multiplier (flush-to-zero, NaN/inf handling, flags); FP_MUL_RNE_EN selects round-to-nearest-even, else truncation.
// Latency: out_valid rises exactly MAN_W+4 cycles after the accept edge, for every operand class.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_mul_seq
   import fp_pkg::*;
#(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     y,
   output logic [FLG_W-1:0] flags
);

   localparam int N  = MAN_W + 1;
   localparam int PW = 2 * N;
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [63:0]  QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
   localparam logic [63:0]  INF_WIDE  = fp_inf(1'b0, EXP_W, MAN_W);
   localparam logic [W-1:0] QNAN      = QNAN_WIDE[W-1:0];
   localparam logic [W-2:0] INF_MAG   = INF_WIDE[W-2:0];

   state_e state_q, state_d;

   logic [W-1:0]           a_q, b_q;
   logic                   sign_q;
   logic signed [XW-1:0]   exp_q;
   logic                   nan_q, inf_q, zero_q, flush_q;
   logic [MAN_W-1:0]       frac_q;
   logic                   grd_q, rnd_q, stk_q;
   logic [W-1:0]           y_q, y_d;
   logic [FLG_W-1:0]       flags_q, flags_d;

   // Operand fields and classification, taken from the captured operands
   logic                   sa, sb;
   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic signed [XW-1:0]   exp_sum;

   assign {sa, ea, fa} = a_q;
   assign {sb, eb, fb} = b_q;
   assign a_zero  = ~|ea;
   assign b_zero  = ~|eb;
   assign a_inf   = (&ea) & ~|fa;
   assign b_inf   = (&eb) & ~|fb;
   assign a_nan   = (&ea) & |fa;
   assign b_nan   = (&eb) & |fb;
   assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   logic            mul_start, mul_done;
   logic [PW-1:0]   prod;

   assign mul_start = (state_q == ST_UNPACK);

   fp_mul_mant_iter #(.N(N)) u_mant (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mul_start),
      .mcand_i  ({~a_zero, fa}),
      .mplier_i ({~b_zero, fb}),
      .done_o   (mul_done),
      .prod_o   (prod)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign y         = y_q;
   assign flags     = flags_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: fixed walk through UNPACK/MUL/NORM/PACK, handshakes only at IDLE and DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid)  state_d = ST_UNPACK;
         ST_UNPACK:                state_d = ST_MUL;
         ST_MUL:    if (mul_done)  state_d = ST_NORM;
         ST_NORM:                  state_d = ST_PACK;
         ST_PACK:                  state_d = ST_DONE;
         ST_DONE:   if (out_ready) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Round, then resolve special operands and exponent range into the result word
   logic [MAN_W:0]       frac_r;
   logic                 inc;
   logic signed [XW-1:0] exp_r;

   always_comb begin
`ifdef FP_MUL_RNE_EN
      inc = grd_q & (rnd_q | stk_q | frac_q[0]);
`else
      inc = 1'b0;
`endif
      frac_r  = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
      exp_r   = exp_q + $signed({{(XW-1){1'b0}}, frac_r[MAN_W]});
      y_d     = '0;
      flags_d = '0;
      if (nan_q) begin
         y_d              = QNAN;
         flags_d[FLG_INV] = 1'b1;
      end else if (inf_q) begin
         y_d = {sign_q, INF_MAG};
      end else if (zero_q) begin
         y_d              = {sign_q, {(W-1){1'b0}}};
         flags_d[FLG_INX] = flush_q;
      end else if (exp_r >= EXP_MAX) begin
         y_d              = {sign_q, INF_MAG};
         flags_d[FLG_OVF] = 1'b1;
         flags_d[FLG_INX] = 1'b1;
      end else if (exp_r <= EXP_ZERO) begin
         y_d              = {sign_q, {(W-1){1'b0}}};
         flags_d[FLG_UNF] = 1'b1;
         flags_d[FLG_INX] = 1'b1;
      end else begin
         y_d              = {sign_q, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
         flags_d[FLG_INX] = grd_q | rnd_q | stk_q;
      end
   end

   // Datapath registers, each stage updating only its own fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         nan_q   <= 1'b0;
         inf_q   <= 1'b0;
         zero_q  <= 1'b0;
         flush_q <= 1'b0;
         frac_q  <= '0;
         grd_q   <= 1'b0;
         rnd_q   <= 1'b0;
         stk_q   <= 1'b0;
         y_q     <= '0;
         flags_q <= '0;
      end else begin
         if (state_q == ST_IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
         end
         if (state_q == ST_UNPACK) begin
            sign_q  <= sa ^ sb;
            exp_q   <= exp_sum;
            nan_q   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf_q   <= a_inf | b_inf;
            zero_q  <= a_zero | b_zero;
            flush_q <= (a_zero & |fa) | (b_zero & |fb);
         end
         // Product lies in [2^(PW-2), 2^PW); a set MSB means one extra integer bit
         if (state_q == ST_NORM) begin
            exp_q  <= exp_q + $signed({{(XW-1){1'b0}}, prod[PW-1]});
            frac_q <= prod[PW-1] ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
            grd_q  <= prod[PW-1] ? prod[N-1] : prod[N-2];
            rnd_q  <= prod[PW-1] ? prod[N-2] : prod[N-3];
            stk_q  <= prod[PW-1] ? |prod[N-3:0] : |prod[N-4:0];
         end
         if (state_q == ST_PACK) begin
            y_q     <= y_d;
            flags_q <= flags_d;
         end
      end
   end

endmodule
